// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one Data_Memory line port between m0 and m1.
// Holds the grant until memory acks; a watchdog parks the block in ERR.
module mem_arbiter #(
  parameter int DATA_W   = 256,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic              m0_ack_o,
  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [1:0]        grant_o,
  output logic              err_o
);

  localparam int CW = $clog2(MAX_WAIT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              last_q, last_d;
  logic [CW-1:0]     wait_q, wait_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              pick0, pick1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      wait_q  <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wait_q  <= wait_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // last_q = 1 means m1 owned the previous grant, so m0 wins a tie
  always_comb begin
    pick0 = m0_enable_i & (~m1_enable_i | last_q);
    pick1 = m1_enable_i & ~pick0;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wait_d  = wait_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (pick0) begin
          state_d = BUSY;
          grant_d = 2'b01;
          last_d  = 1'b0;
          wait_d  = '0;
          wr_d    = m0_write_i;
          addr_d  = m0_addr_i;
          data_d  = m0_data_i;
        end else if (pick1) begin
          state_d = BUSY;
          grant_d = 2'b10;
          last_d  = 1'b1;
          wait_d  = '0;
          wr_d    = m1_write_i;
          addr_d  = m1_addr_i;
          data_d  = m1_data_i;
        end
      end
      BUSY: begin
        if (mem_ack_i) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ERR;
          grant_d = 2'b00;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ERR: begin
        grant_d = 2'b00;
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_comb begin
    mem_enable_o = (state_q == BUSY);
    err_o        = (state_q == ERR);
    grant_o      = grant_q;
    mem_write_o  = wr_q;
    mem_addr_o   = addr_q;
    mem_data_o   = data_q;
    rd_data_o    = mem_data_i;
    m0_ack_o     = mem_ack_i & grant_q[0] & (state_q == BUSY);
    m1_ack_o     = mem_ack_i & grant_q[1] & (state_q == BUSY);
  end

endmodule
